// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
// Bundles every signal between the ID/EX operand stage and its neighbours.
// The clock and reset are not part of the bundle.
//   master : the surrounding pipeline. It drives the ID fields, the stall and
//            flush controls and the EX/MEM and MEM/WB writeback taps. It
//            receives the EX operands and hazard_stall.
//   slave  : the operand stage itself.
// Parameters: WIDTH (datapath width), REG_AW (register index width).
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
);
  // pipeline control
  logic              stall;
  logic              flush;
  // decoded instruction from ID
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [WIDTH-1:0]  id_rs1_data;
  logic [WIDTH-1:0]  id_rs2_data;
  logic [WIDTH-1:0]  id_imm;
  logic              id_alusrc;
  logic [1:0]        id_alu_sel;
  logic [3:0]        id_ctrl;      // {regwrite, memread, memwrite, branch}
  // later-stage writeback taps
  logic              exmem_regwrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [WIDTH-1:0]  exmem_result;
  logic              memwb_regwrite;
  logic [REG_AW-1:0] memwb_rd;
  logic [WIDTH-1:0]  memwb_result;
  // EX-side outputs
  logic              ex_valid;
  logic [WIDTH-1:0]  ex_a;
  logic [WIDTH-1:0]  ex_b;
  logic [1:0]        ex_alu_sel;
  logic [WIDTH-1:0]  ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic [3:0]        ex_ctrl;
  logic              hazard_stall;

  modport master (
    output stall, flush,
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
    output id_alusrc, id_alu_sel, id_ctrl,
    output exmem_regwrite, exmem_rd, exmem_result,
    output memwb_regwrite, memwb_rd, memwb_result,
    input  ex_valid, ex_a, ex_b, ex_alu_sel, ex_store_data, ex_rd, ex_ctrl,
    input  hazard_stall
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
    input  id_alusrc, id_alu_sel, id_ctrl,
    input  exmem_regwrite, exmem_rd, exmem_result,
    input  memwb_regwrite, memwb_rd, memwb_result,
    output ex_valid, ex_a, ex_b, ex_alu_sel, ex_store_data, ex_rd, ex_ctrl,
    output hazard_stall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register and operand delivery for the 64-bit ALU.
// Latency is one cycle from ID to the ALU inputs.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset; every stage register clears
//   stage_io : id_ex_operand_stage_if.slave. It carries the ID fields,
//              stall/flush, the EX/MEM and MEM/WB taps, the EX operands
//              (ex_a, ex_b, ex_store_data, ex_alu_sel, ex_rd, ex_ctrl,
//              ex_valid) and hazard_stall.
//
// Configuration macro ID_EX_FWD_EN:
//   defined   : EX/MEM then MEM/WB results are forwarded onto the operands,
//               and only load-use dependencies stall.
//   undefined : the operands use the registered register-file data only.
//               Any RAW dependency on the instruction in EX or in EX/MEM also
//               stalls. MEM/WB is covered by the register file's
//               write-before-read.
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31
) (
  input logic                   clk,
  input logic                   rst_n,
  id_ex_operand_stage_if.slave  stage_io
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_MEMREAD  = 2;

  // One EX slot; an all-zero slot is a bubble, because ex_ctrl=0 never
  // writes registers or memory.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [WIDTH-1:0]  imm;
    logic              alusrc;
    logic [1:0]        alu_sel;
    logic [3:0]        ctrl;
  } slot_t;

  slot_t             slot_q;
  slot_t             slot_d;
  logic              load_use_s;
  logic              raw_s;
  logic              hazard_s;
  logic              id_uses_ex_rd_s;
  logic [WIDTH-1:0]  fwd_rs1_s;
  logic [WIDTH-1:0]  fwd_rs2_s;
  logic [WIDTH-1:0]  ex_b_s;

`ifdef ID_EX_FWD_EN
  // EX/MEM wins over MEM/WB; XZR is never taken as a forwarding source.
  function automatic logic [WIDTH-1:0] fwd_f(
    input logic [REG_AW-1:0] rs,
    input logic [WIDTH-1:0]  rf_data,
    input logic              xm_we,
    input logic [REG_AW-1:0] xm_rd,
    input logic [WIDTH-1:0]  xm_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [WIDTH-1:0]  mw_res
  );
    logic [WIDTH-1:0] r;
    if (xm_we && (xm_rd != ZERO_IDX) && (xm_rd == rs)) begin
      r = xm_res;
    end else if (mw_we && (mw_rd != ZERO_IDX) && (mw_rd == rs)) begin
      r = mw_res;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction
`endif

  // Hazard detection: the load-use term always applies, and the extra RAW
  // terms apply only when forwarding is absent.
  always_comb begin
    id_uses_ex_rd_s = (stage_io.id_rs1 == slot_q.rd) || (stage_io.id_rs2 == slot_q.rd);
    load_use_s = stage_io.id_valid & slot_q.valid & slot_q.ctrl[CTRL_MEMREAD] &
                 (slot_q.rd != ZERO_IDX) & id_uses_ex_rd_s;
`ifdef ID_EX_FWD_EN
    raw_s = 1'b0;
`else
    raw_s = stage_io.id_valid &
            ((slot_q.valid & slot_q.ctrl[CTRL_REGWRITE] & (slot_q.rd != ZERO_IDX) &
              id_uses_ex_rd_s) |
             (stage_io.exmem_regwrite & (stage_io.exmem_rd != ZERO_IDX) &
              ((stage_io.id_rs1 == stage_io.exmem_rd) ||
               (stage_io.id_rs2 == stage_io.exmem_rd))));
`endif
    if (stage_io.flush) begin
      hazard_s = 1'b0;
    end else begin
      hazard_s = load_use_s | raw_s;
    end
  end

  // Next-state selection in priority order: flush, stall, hazard bubble, load.
  always_comb begin
    slot_d = slot_q;
    if (stage_io.flush) begin
      slot_d = '0;
    end else if (stage_io.stall) begin
      slot_d = slot_q;
    end else if (hazard_s) begin
      slot_d = '0;
    end else begin
      slot_d.valid    = stage_io.id_valid;
      slot_d.rs1      = stage_io.id_rs1;
      slot_d.rs2      = stage_io.id_rs2;
      slot_d.rd       = stage_io.id_rd;
      slot_d.rs1_data = stage_io.id_rs1_data;
      slot_d.rs2_data = stage_io.id_rs2_data;
      slot_d.imm      = stage_io.id_imm;
      slot_d.alusrc   = stage_io.id_alusrc;
      slot_d.alu_sel  = stage_io.id_alu_sel;
      slot_d.ctrl     = stage_io.id_ctrl;
    end
  end

  // ID/EX stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Operand sources; forwarding is evaluated even for bubbles.
  always_comb begin
`ifdef ID_EX_FWD_EN
    fwd_rs1_s = fwd_f(slot_q.rs1, slot_q.rs1_data,
                      stage_io.exmem_regwrite, stage_io.exmem_rd, stage_io.exmem_result,
                      stage_io.memwb_regwrite, stage_io.memwb_rd, stage_io.memwb_result);
    fwd_rs2_s = fwd_f(slot_q.rs2, slot_q.rs2_data,
                      stage_io.exmem_regwrite, stage_io.exmem_rd, stage_io.exmem_result,
                      stage_io.memwb_regwrite, stage_io.memwb_rd, stage_io.memwb_result);
`else
    fwd_rs1_s = slot_q.rs1_data;
    fwd_rs2_s = slot_q.rs2_data;
`endif
    if (slot_q.alusrc) begin
      ex_b_s = slot_q.imm;
    end else begin
      ex_b_s = fwd_rs2_s;
    end
  end

`ifndef ID_EX_FWD_EN
  // These fields are carried only for forwarding.
  logic unused_nofwd_s;
  assign unused_nofwd_s = ^{slot_q.rs1, slot_q.rs2, stage_io.exmem_result,
                            stage_io.memwb_regwrite, stage_io.memwb_rd,
                            stage_io.memwb_result};
`endif

  assign stage_io.ex_valid      = slot_q.valid;
  assign stage_io.ex_a          = fwd_rs1_s;
  assign stage_io.ex_b          = ex_b_s;
  assign stage_io.ex_alu_sel    = slot_q.alu_sel;
  assign stage_io.ex_store_data = fwd_rs2_s;
  assign stage_io.ex_rd         = slot_q.rd;
  assign stage_io.ex_ctrl       = slot_q.ctrl;
  assign stage_io.hazard_stall  = hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
// Scoreboard bench for id_ex_operand_stage. It runs directed scenarios and
// then randomized traffic. The driver predicts the outputs for each cycle
// from an instruction-level model of the EX slot and queues them. A separate
// monitor compares the DUT outputs against the queue every cycle.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

  localparam int W  = 64;
  localparam int AW = 5;
  localparam logic [4:0] XZR = 5'd31;
`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.WIDTH(W), .REG_AW(AW)) bus ();

  id_ex_operand_stage #(.WIDTH(W), .REG_AW(AW), .ZERO_REG(31)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stage_io (bus)
  );

  typedef struct packed {
    logic rst_n, stall, flush, id_valid;
    logic [4:0] rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic alusrc;
    logic [1:0] sel;
    logic [3:0] ctrl;
    logic xm_we; logic [4:0] xm_rd; logic [63:0] xm_res;
    logic mw_we; logic [4:0] mw_rd; logic [63:0] mw_res;
  } in_t;

  // Instruction currently in EX (all zero = bubble / reset)
  typedef struct packed {
    logic valid;
    logic [4:0] rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic alusrc;
    logic [1:0] sel;
    logic [3:0] ctrl;
  } slot_t;

  typedef struct {
    logic valid; logic [3:0] ctrl; logic [4:0] rd; logic [1:0] sel;
    logic [63:0] a, b, sd; logic hz; string tag;
  } exp_t;

  exp_t  sb_q[$];
  slot_t ex;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic in_t idle();
    in_t i = '0;
    i.rst_n = 1'b1;
    return i;
  endfunction

  function automatic logic [4:0] rreg();
    int r = $urandom_range(0, 8);
    return (r == 8) ? XZR : r[4:0];
  endfunction

  function automatic in_t rnd();
    in_t i = idle();
    i.rst_n    = ($urandom_range(0, 199) != 0);
    i.stall    = ($urandom_range(0, 5) == 0);
    i.flush    = ($urandom_range(0, 9) == 0);
    i.id_valid = ($urandom_range(0, 3) != 0);
    i.rs1 = rreg(); i.rs2 = rreg(); i.rd = rreg();
    i.d1  = {$urandom(), $urandom()};
    i.d2  = {$urandom(), $urandom()};
    i.imm = {$urandom(), $urandom()};
    i.alusrc = $urandom_range(0, 1);
    i.sel    = 2'($urandom_range(0, 2));
    i.ctrl   = 4'($urandom_range(0, 15));
    i.xm_we = $urandom_range(0, 1); i.xm_rd = rreg(); i.xm_res = {$urandom(), $urandom()};
    i.mw_we = $urandom_range(0, 1); i.mw_rd = rreg(); i.mw_res = {$urandom(), $urandom()};
    return i;
  endfunction

  // Value a source register carries into the ALU.
  function automatic logic [63:0] m_src(logic [4:0] rs, logic [63:0] rf, in_t i);
    if (FWD_EN && i.xm_we && i.xm_rd != XZR && i.xm_rd == rs) return i.xm_res;
    if (FWD_EN && i.mw_we && i.mw_rd != XZR && i.mw_rd == rs) return i.mw_res;
    return rf;
  endfunction

  function automatic logic m_hazard(in_t i, slot_t s);
    logic dep_ex, dep_xm;
    dep_ex = (i.rs1 == s.rd) || (i.rs2 == s.rd);
    dep_xm = (i.rs1 == i.xm_rd) || (i.rs2 == i.xm_rd);
    if (i.flush || !i.id_valid) return 1'b0;
    // load in EX feeding ID
    if (s.valid && s.ctrl[2] && s.rd != XZR && dep_ex) return 1'b1;
    if (!FWD_EN) begin
      if (s.valid && s.ctrl[3] && s.rd != XZR && dep_ex) return 1'b1;
      if (i.xm_we && i.xm_rd != XZR && dep_xm) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive one cycle, predict its outputs, then advance the model across the edge.
  task automatic apply(in_t i, string tag);
    exp_t  e;
    slot_t nx;
    logic  hz;
    @(negedge clk);
    rst_n = i.rst_n;
    bus.stall = i.stall; bus.flush = i.flush; bus.id_valid = i.id_valid;
    bus.id_rs1 = i.rs1; bus.id_rs2 = i.rs2; bus.id_rd = i.rd;
    bus.id_rs1_data = i.d1; bus.id_rs2_data = i.d2; bus.id_imm = i.imm;
    bus.id_alusrc = i.alusrc; bus.id_alu_sel = i.sel; bus.id_ctrl = i.ctrl;
    bus.exmem_regwrite = i.xm_we; bus.exmem_rd = i.xm_rd; bus.exmem_result = i.xm_res;
    bus.memwb_regwrite = i.mw_we; bus.memwb_rd = i.mw_rd; bus.memwb_result = i.mw_res;
    #1;
    if (!i.rst_n) ex = '0;
    hz = m_hazard(i, ex);
    e.valid = ex.valid; e.ctrl = ex.ctrl; e.rd = ex.rd; e.sel = ex.sel;
    e.a  = m_src(ex.rs1, ex.d1, i);
    e.sd = m_src(ex.rs2, ex.d2, i);
    e.b  = ex.alusrc ? ex.imm : e.sd;
    e.hz = hz;
    e.tag = tag;
    sb_q.push_back(e);
    nx = ex;
    if (!i.rst_n || i.flush) nx = '0;
    else if (i.stall) nx = ex;
    else if (hz) nx = '0;
    else nx = '{valid: i.id_valid, rs1: i.rs1, rs2: i.rs2, rd: i.rd, d1: i.d1, d2: i.d2,
                imm: i.imm, alusrc: i.alusrc, sel: i.sel, ctrl: i.ctrl};
    ex = nx;
  endtask

  task automatic chk(string tag, string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%h expected 0x%h (t=%0t)", tag, name, act, expv, $time);
    end
  endtask

  // Monitor: compare every cycle's DUT outputs against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "ex_valid",      64'(bus.ex_valid),      64'(e.valid));
        chk(e.tag, "ex_ctrl",       64'(bus.ex_ctrl),       64'(e.ctrl));
        chk(e.tag, "ex_rd",         64'(bus.ex_rd),         64'(e.rd));
        chk(e.tag, "ex_alu_sel",    64'(bus.ex_alu_sel),    64'(e.sel));
        chk(e.tag, "ex_a",          bus.ex_a,               e.a);
        chk(e.tag, "ex_b",          bus.ex_b,               e.b);
        chk(e.tag, "ex_store_data", bus.ex_store_data,      e.sd);
        chk(e.tag, "hazard_stall",  64'(bus.hazard_stall),  64'(e.hz));
      end
    end
  end

  initial begin
    in_t i, j;
    ex = '0;

    // reset held
    i = idle(); i.rst_n = 1'b0;
    apply(i, "reset0"); apply(i, "reset1");

    // first instruction after release: ex_a=5 next cycle
    i = idle(); i.id_valid = 1'b1; i.rs1 = 5'd1; i.d1 = 64'd5; i.rd = 5'd2;
    apply(i, "release");
    apply(idle(), "release_ex");

    // EX/MEM beats MEM/WB, then MEM/WB alone
    i = idle(); i.id_valid = 1'b1; i.rs1 = 5'd3; i.rs2 = 5'd6; i.rd = 5'd9;
    i.ctrl = 4'b1000; i.sel = 2'b10; i.d1 = 64'hAA;
    apply(i, "prio_load");
    j = idle(); j.stall = 1'b1;
    j.xm_we = 1'b1; j.xm_rd = 5'd3; j.xm_res = 64'h10;
    j.mw_we = 1'b1; j.mw_rd = 5'd3; j.mw_res = 64'h20;
    apply(j, "prio_exmem");
    j.xm_we = 1'b0;
    apply(j, "prio_memwb");

    // XZR never forwarded
    i = idle(); i.id_valid = 1'b1; i.rs1 = XZR; i.d1 = 64'd0;
    apply(i, "xzr_load");
    j = idle(); j.stall = 1'b1; j.xm_we = 1'b1; j.xm_rd = XZR; j.xm_res = 64'hDEAD;
    apply(j, "xzr_fwd");

    // load-use: bubble, then dependent instruction enters
    i = idle(); i.id_valid = 1'b1; i.rd = 5'd4; i.ctrl = 4'b1100; i.rs1 = 5'd1; i.rs2 = 5'd2;
    apply(i, "lu_load");
    j = idle(); j.id_valid = 1'b1; j.rs1 = 5'd5; j.rs2 = 5'd4; j.rd = 5'd6;
    j.ctrl = 4'b1000; j.d2 = 64'h77;
    apply(j, "lu_detect");
    apply(j, "lu_bubble");
    i = idle(); i.stall = 1'b1; i.mw_we = 1'b1; i.mw_rd = 5'd4; i.mw_res = 64'h1234;
    apply(i, "lu_enter");

    // immediate select vs. forwarded store data
    i = idle(); i.id_valid = 1'b1; i.rs2 = 5'd7; i.alusrc = 1'b1;
    i.imm = 64'hFFFF_FFFF_FFFF_FFF8; i.d2 = 64'd3;
    apply(i, "imm_load");
    j = idle(); j.stall = 1'b1; j.xm_we = 1'b1; j.xm_rd = 5'd7; j.xm_res = 64'd7;
    apply(j, "imm_sel");

    // flush beats stall; stall alone holds for 3 cycles
    i = idle(); i.id_valid = 1'b1; i.sel = 2'b10; i.ctrl = 4'b1001; i.rd = 5'd8;
    i.d1 = 64'h55; i.d2 = 64'h66;
    apply(i, "fs_load");
    j = i; j.flush = 1'b1; j.stall = 1'b1;
    apply(j, "fs_both");
    apply(i, "fs_bubble");
    for (int k = 0; k < 3; k++) begin
      j = rnd(); j.rst_n = 1'b1; j.flush = 1'b0; j.stall = 1'b1;
      apply(j, "stall_hold");
    end
    apply(idle(), "stall_done");

    // asynchronous reset mid-stream
    i = idle(); i.id_valid = 1'b1; i.rs1 = 5'd2; i.d1 = 64'h99; i.ctrl = 4'b1000; i.rd = 5'd3;
    apply(i, "mid_load");
    i.rst_n = 1'b0;
    apply(i, "mid_reset");
    i.rst_n = 1'b1;
    apply(i, "mid_release");

    // randomized traffic
    for (int k = 0; k < 600; k++) apply(rnd(), "random");

    apply(idle(), "drain");
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-delivery stage that directly feeds the 64-bit ALU (A, B, ALU_Sel). It registers decoded operands and controls, forwards results from EX/MEM and MEM/WB onto A/B, and detects load-use hazards, inserting a bubble when one occurs. Latency is one cycle from ID to the ALU inputs.

Parameters:
WIDTH, 64, datapath width of operands and results
REG_AW, 5, register-index width
ZERO_REG, 31, index of the hard-zero register (XZR); never forwarded, never a hazard source

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  downstream hold; all stage registers keep their value
flush  in  1  branch flush; the next edge loads a bubble
id_valid  in  1  ID holds a valid instruction
id_rs1 / id_rs2 / id_rd  in  REG_AW  source and destination indices
id_rs1_data / id_rs2_data  in  WIDTH  register-file read data
id_imm  in  WIDTH  sign-extended immediate
id_alusrc  in  1  1: ALU B takes the immediate
id_alu_sel  in  2  ALU op (00 AND, 01 OR, 10 ADD)
id_ctrl  in  4  {regwrite, memread, memwrite, branch}
exmem_regwrite / memwb_regwrite  in  1  later-stage write enables
exmem_rd / memwb_rd  in  REG_AW  later-stage destinations
exmem_result / memwb_result  in  WIDTH  later-stage results
ex_valid  out  1  EX holds a valid instruction
ex_a / ex_b  out  WIDTH  ALU A/B (combinational after the registers)
ex_alu_sel  out  2  ALU_Sel
ex_store_data  out  WIDTH  forwarded rs2 value, for stores
ex_rd  out  REG_AW  registered destination
ex_ctrl  out  4  registered controls
hazard_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (async, rst_n=0):
  - All registers clear.
  - ex_valid=0, ex_ctrl=0, ex_alu_sel=00, ex_rd=0.
  - Registered data=0, so ex_a=ex_b=ex_store_data=0 unless forwarding applies.
  - Outputs return to reset values immediately, even mid-instruction.
- Update priority at each rising edge:
  1. flush=1: load a bubble (ex_valid=0, ex_ctrl=0). Data registers are don't-care; they clear to 0.
  2. stall=1: hold every register.
  3. hazard_stall=1: load a bubble.
  4. Otherwise: load all id_* fields; ex_valid=id_valid.
- Bubble: ex_ctrl=0, so a bubble never writes registers or memory.
- Load-use detection (combinational):
  - hazard_stall = id_valid & ex_valid & ex_ctrl.memread & ex_rd!=ZERO_REG & (id_rs1==ex_rd | id_rs2==ex_rd).
  - Asserted regardless of the stall input.
  - Forced to 0 while flush=1.
- Forwarding (combinational), per source rs1 and rs2:
  - Candidate from EX/MEM when exmem_regwrite & exmem_rd!=ZERO_REG & exmem_rd==registered rs.
  - Else candidate from MEM/WB under the same rule.
  - Else the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match.
- Operand selection:
  - ex_a = forwarded rs1.
  - ex_b = registered imm if alusrc=1, else forwarded rs2.
  - ex_store_data = forwarded rs2 always.
- Forwarding still evaluates when ex_valid=0; downstream ignores the result.
- Widths: no arithmetic is performed here; all data paths are WIDTH bits, with no truncation or extension.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding exactly as above.
- Undefined:
  - ex_a/ex_b/ex_store_data take registered register-file data only.
  - hazard_stall also asserts on any RAW dependency against EX (ex_ctrl.regwrite, ex_rd!=ZERO_REG) or EX/MEM (exmem_regwrite, exmem_rd!=ZERO_REG) on id_rs1/id_rs2, whether or not the producer is a load.
  - MEM/WB is covered by the register file's write-before-read.

Test Plan:
- Reset: assert rst_n=0 mid-stream with id_valid=1 -> ex_valid=0, ex_ctrl=0, ex_a=0 immediately; after release with id_valid=1, rs1_data=5, next edge -> ex_a=5, ex_valid=1.
- EX/MEM priority: EX holds rs1=3; exmem_rd=3, exmem_result=0x10, exmem_regwrite=1; memwb_rd=3, memwb_result=0x20 -> ex_a=0x10. Drop exmem_regwrite -> ex_a=0x20.
- XZR: exmem_rd=31, regwrite=1, registered rs1=31, rs1_data=0 -> ex_a=0, no forward.
- Load-use: EX holds a load with ex_rd=4; ID has rs2=4 -> hazard_stall=1; next edge ex_valid=0, ex_ctrl=0; then the instruction enters with ex_b=memwb_result.
- Immediate select: alusrc=1, imm=0xFFFF_FFFF_FFFF_FFF8, rs2 forwarded to 7 -> ex_b=imm, ex_store_data=7.
- Priority: flush=1 and stall=1 together -> next edge ex_valid=0. stall=1 alone for 3 cycles -> all outputs held, including ex_alu_sel=10.
